pacman_motion_controller: RTL

- Drives the character position write port of the VGA generator (nios_char_data_pos / nios_char_wraddress_pos / nios_char_wren_pos) from four push-buttons, in hardware, with no Nios involvement.
- Sits directly upstream of the VGA generator and runs on the same clock as the write port.
- Debounces the buttons, holds the current direction, steps the sprite once every FRAME_DIV frames on the start-of-frame pulse, clamps the position to the maze bounds, and writes X then Y to the position RAM.

---
 rtl/pacman_motion_controller.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pacman_motion_controller.sv
// Button-driven sprite mover: debounced keys set a direction, every FRAME_DIV frames the clamped position is written (X then Y).
// Latency: frame tick -> first write strobe 2 cycles; no backpressure, the position RAM port always accepts.
module pacman_motion_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FRAME_DIV       = 2,
    parameter int STEP            = 4,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 1888,
    parameter int Y_MIN           = 0,
    parameter int Y_MAX           = 1048,
    parameter int X_INIT          = 944,
    parameter int Y_INIT          = 524
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  key_n,
    input  logic        new_image,
    input  logic        enable,
    output logic [11:0] wr_data,
    output logic [1:0]  wr_addr,
    output logic        wr_en,
    output logic [11:0] pos_x,
    output logic [11:0] pos_y,
    output logic [1:0]  dir,
    output logic        moving
);

    localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]      DIV_LAST = 4'(FRAME_DIV - 1);
    localparam logic [12:0]     STEP_W  = 13'(STEP);
    localparam logic [12:0]     XMIN_W  = 13'(X_MIN);
    localparam logic [12:0]     XMAX_W  = 13'(X_MAX);
    localparam logic [12:0]     YMIN_W  = 13'(Y_MIN);
    localparam logic [12:0]     YMAX_W  = 13'(Y_MAX);

    typedef enum logic [2:0] {INIT, IDLE, CALC, WR_X, WR_Y} state_t;

    logic [3:0]    sync1, sync2, accepted, accepted_d, press;
    logic [CW-1:0] db_cnt [4];
    logic          ni_d1, ni_d2, tick, due;
    logic [3:0]    div;
    state_t        state, next_state;
    logic [11:0]   pos_x_nxt, pos_y_nxt, step_x, step_y;
    logic [12:0]   x_w, y_w;

    // A key is accepted only after its synchronized level has disagreed with the accepted level for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '1;
            sync2      <= '1;
            accepted   <= '1;
            accepted_d <= '1;
            for (int k = 0; k < 4; k++) db_cnt[k] <= '0;
        end else begin
            sync1      <= key_n;
            sync2      <= sync1;
            accepted_d <= accepted;
            for (int k = 0; k < 4; k++) begin
                if (sync2[k] == accepted[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_LAST) begin
                    accepted[k] <= sync2[k];
                    db_cnt[k]   <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign press = accepted_d & ~accepted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir    <= 2'd0;
            moving <= 1'b0;
        end else if (press != 4'd0) begin
            moving <= 1'b1;
            if (press[0])      dir <= 2'd0;
            else if (press[1]) dir <= 2'd1;
            else if (press[2]) dir <= 2'd2;
            else               dir <= 2'd3;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ni_d1 <= 1'b0;
            ni_d2 <= 1'b0;
            tick  <= 1'b0;
            div   <= 4'd0;
        end else begin
            ni_d1 <= new_image;
            ni_d2 <= ni_d1;
            tick  <= ni_d1 & ~ni_d2;
            if (tick) div <= (div == DIV_LAST) ? 4'd0 : div + 4'd1;
        end
    end

    assign due = tick && (div == DIV_LAST);
    assign x_w = {1'b0, pos_x};
    assign y_w = {1'b0, pos_y};

    // Clamp tests are done in 13 bits so a decrement below zero saturates instead of wrapping.
    always_comb begin
        step_x = pos_x;
        step_y = pos_y;
        case (dir)
            2'd0: step_y = (y_w < YMIN_W + STEP_W) ? 12'(Y_MIN) : 12'(y_w - STEP_W);
            2'd1: step_y = (y_w + STEP_W > YMAX_W) ? 12'(Y_MAX) : 12'(y_w + STEP_W);
            2'd2: step_x = (x_w < XMIN_W + STEP_W) ? 12'(X_MIN) : 12'(x_w - STEP_W);
            default: step_x = (x_w + STEP_W > XMAX_W) ? 12'(X_MAX) : 12'(x_w + STEP_W);
        endcase
    end

    always_comb begin
        next_state = state;
        pos_x_nxt  = pos_x;
        pos_y_nxt  = pos_y;
        case (state)
            INIT: next_state = WR_X;
            IDLE: if (due && moving && enable) next_state = CALC;
            CALC: begin
                next_state = WR_X;
                pos_x_nxt  = step_x;
                pos_y_nxt  = step_y;
            end
            WR_X: next_state = WR_Y;
            WR_Y: next_state = IDLE;
            default: next_state = INIT;
        endcase
    end

    // Write port is registered from next_state so the strobe lines up with the state it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= INIT;
            pos_x   <= 12'(X_INIT);
            pos_y   <= 12'(Y_INIT);
            wr_en   <= 1'b0;
            wr_addr <= 2'd0;
            wr_data <= 12'd0;
        end else begin
            state   <= next_state;
            pos_x   <= pos_x_nxt;
            pos_y   <= pos_y_nxt;
            wr_en   <= (next_state == WR_X) || (next_state == WR_Y);
            wr_addr <= (next_state == WR_Y) ? 2'd1 : 2'd0;
            if (next_state == WR_X)      wr_data <= pos_x_nxt;
            else if (next_state == WR_Y) wr_data <= pos_y_nxt;
            else                         wr_data <= 12'd0;
        end
    end

endmodule
